branch_predictor_gshare: RTL and testbench

//  Parametrised IF-stage branch predictor replacing the single-entry static predictor: BHT of saturating counters (bimodal or gshare indexed) plus tagged direct-mapped BTB.

---
 rtl/branch_predictor_gshare_pkg.sv | 48 ++++
 rtl/branch_predictor_gshare_btb.sv | 73 +++++++
 rtl/branch_predictor_gshare.sv | 167 ++++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_gshare_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_predictor_gshare_pkg
// Purpose : Shared types for the IF-stage branch predictor. Contains the
//           BHT indexing mode, the BTB entry layout, the predictor word that
//           the pipeline carries IF->ID->EX, and a BTB tag extraction helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package branch_predictor_gshare_pkg;

  typedef enum logic {
    BRP_BIMODAL = 1'b0,
    BRP_GSHARE  = 1'b1
  } brp_mode_t;

  // Widest tag any legal BTB_IDX can need (PC[31:2] with BTB_IDX = 0).
  // Narrower tags are stored zero-extended, so one struct serves every size.
  localparam int unsigned BRP_TAG_MAX_W = 30;
  // Widest GHR the pipeline stage registers are prepared to carry.
  localparam int unsigned BRP_GHR_MAX_W = 16;

  typedef struct packed {
    logic                     valid;
    logic [BRP_TAG_MAX_W-1:0] tag;
    logic [31:0]              target;
    logic                     is_jal;
  } btb_entry_t;

  // Prediction metadata carried with the instruction through IF->ID->EX.
  typedef struct packed {
    logic                     pred_taken;
    logic [31:0]              pred_target;
    logic [BRP_GHR_MAX_W-1:0] ghr;
  } rv32i_brp_word;

  // Tag = PC bits above the BTB index field, zero-extended.
  function automatic logic [BRP_TAG_MAX_W-1:0] brp_tag(
    input logic [31:0] pc,
    input int unsigned idx_w
  );
    logic [31:0] shifted;
    shifted = pc >> (idx_w + 2);
    return shifted[BRP_TAG_MAX_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_gshare_btb.sv
`default_nettype none
// ============================================================================
// Module  : brp_btb
// Purpose : Tagged direct-mapped branch target buffer. Combinational read
//           indexed by the fetch PC, synchronous write from EX resolution.
//           A write replaces the whole entry (direct-mapped, no ways).
// Ports   : clk, rst          - clock, async active-high reset (clears valid)
//           rd_pc_i           - lookup PC
//           rd_hit_o          - entry valid and tag matches
//           rd_target_o       - stored target for the looked-up entry
//           rd_is_jal_o       - stored entry is an unconditional jal
//           wr_en_i           - write enable (already qualified by caller)
//           wr_pc_i           - PC of the resolved branch
//           wr_target_i       - resolved taken target
//           wr_is_jal_i       - resolved instruction is jal
// Revision: 1.0 - initial release
// ============================================================================
module brp_btb
  import branch_predictor_gshare_pkg::*;
#(
  parameter int unsigned BTB_IDX = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc_i,
  output logic        rd_hit_o,
  output logic [31:0] rd_target_o,
  output logic        rd_is_jal_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_pc_i,
  input  logic [31:0] wr_target_i,
  input  logic        wr_is_jal_i
);

  localparam int unsigned DEPTH = 1 << BTB_IDX;

  btb_entry_t entry_q [DEPTH];

  logic [BTB_IDX-1:0]       rd_idx;
  logic [BTB_IDX-1:0]       wr_idx;
  logic [BRP_TAG_MAX_W-1:0] rd_tag;
  btb_entry_t               rd_entry;
  btb_entry_t               wr_entry_d;

  assign rd_idx   = rd_pc_i[BTB_IDX+1:2];
  assign wr_idx   = wr_pc_i[BTB_IDX+1:2];
  assign rd_tag   = brp_tag(rd_pc_i, BTB_IDX);
  assign rd_entry = entry_q[rd_idx];

  assign rd_hit_o    = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign rd_target_o = rd_entry.target;
  assign rd_is_jal_o = rd_entry.is_jal;

  always_comb begin
    wr_entry_d        = '0;
    wr_entry_d.valid  = 1'b1;
    wr_entry_d.tag    = brp_tag(wr_pc_i, BTB_IDX);
    wr_entry_d.target = wr_target_i;
    wr_entry_d.is_jal = wr_is_jal_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      entry_q[wr_idx] <= wr_entry_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module  : branch_predictor_gshare
// Purpose : IF-stage branch predictor: BHT of saturating counters indexed
//           bimodally or by gshare hash, plus a tagged direct-mapped BTB.
//           Prediction is combinational from the fetch PC; training comes
//           from EX resolution. Perf counters count resolved branches and
//           mispredictions.
// Ports   : clk, rst        - clock, async active-high reset
//           stall_i         - freezes every piece of state
//           pc_if_i         - fetch PC
//           pred_taken_o    - redirect fetch to pred_target_o
//           pred_hit_o      - BTB hit for pc_if_i
//           pred_target_o   - predicted next PC (pc_if_i+4 when not taken)
//           pred_ghr_o      - GHR snapshot travelling with the instruction
//           upd_*_i         - EX resolution of a br/jal
//           br_count_o      - resolved br/jal count (wraps)
//           mp_count_o      - mispredict count (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int unsigned BHT_IDX = 6,
  parameter int unsigned BTB_IDX = 5,
  parameter int unsigned GHR_W   = 6,   // must be <= BHT_IDX
  parameter int unsigned CNT_W   = 2,
  parameter brp_mode_t   MODE    = BRP_GSHARE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic [31:0]      pc_if_i,
  output logic             pred_taken_o,
  output logic             pred_hit_o,
  output logic [31:0]      pred_target_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic             upd_is_jal_i,
  input  logic [31:0]      upd_pc_i,
  input  logic [GHR_W-1:0] upd_ghr_i,
  input  logic             upd_taken_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_mispred_i,
  output logic [31:0]      br_count_o,
  output logic [31:0]      mp_count_o
);

  localparam int unsigned BHT_DEPTH = 1 << BHT_IDX;
  // Weakly-not-taken: MSB clear, all lower bits set.
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] bht_q [BHT_DEPTH];
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [31:0]      br_count_q, br_count_d;
  logic [31:0]      mp_count_q, mp_count_d;

  logic               commit;
  logic [BHT_IDX-1:0] pred_idx;
  logic [BHT_IDX-1:0] upd_idx;
  logic [CNT_W-1:0]   pred_ctr;
  logic [CNT_W-1:0]   upd_ctr;
  logic [CNT_W-1:0]   upd_ctr_d;
  logic               btb_hit;
  logic [31:0]        btb_target;
  logic               btb_is_jal;

  assign commit = upd_valid_i && !stall_i;

  // ---------------------------------------------------------------------
  // BHT index: the GHR is zero-extended to the index width before the XOR,
  // so with GHR_W < BHT_IDX only the low index bits see history.
  // ---------------------------------------------------------------------
  always_comb begin
    pred_idx = pc_if_i[BHT_IDX+1:2];
    upd_idx  = upd_pc_i[BHT_IDX+1:2];
    if (MODE == BRP_GSHARE) begin
      pred_idx = pred_idx ^ BHT_IDX'(ghr_q);
      upd_idx  = upd_idx ^ BHT_IDX'(upd_ghr_i);
    end
  end

  // ---------------------------------------------------------------------
  // Prediction (reads the pre-update state; no bypass from the write port)
  // ---------------------------------------------------------------------
  assign pred_ctr = bht_q[pred_idx];

  brp_btb #(
    .BTB_IDX (BTB_IDX)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .rd_pc_i     (pc_if_i),
    .rd_hit_o    (btb_hit),
    .rd_target_o (btb_target),
    .rd_is_jal_o (btb_is_jal),
    .wr_en_i     (commit && upd_taken_i),
    .wr_pc_i     (upd_pc_i),
    .wr_target_i (upd_target_i),
    .wr_is_jal_i (upd_is_jal_i)
  );

  assign pred_hit_o    = btb_hit;
  assign pred_taken_o  = btb_hit && (btb_is_jal || pred_ctr[CNT_W-1]);
  assign pred_target_o = pred_taken_o ? btb_target : (pc_if_i + 32'd4);
  assign pred_ghr_o    = ghr_q;

  // ---------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------
  assign upd_ctr = bht_q[upd_idx];

  always_comb begin
    upd_ctr_d = upd_ctr;
    if (upd_taken_i) begin
      if (upd_ctr != CNT_MAX) upd_ctr_d = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != '0) upd_ctr_d = upd_ctr - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else if (commit && !upd_is_jal_i) begin
      bht_q[upd_idx] <= upd_ctr_d;
    end
  end

  // History only records conditional branch outcomes, and only at
  // resolution time, so it never needs repair after a mispredict.
  always_comb begin
    ghr_d = ghr_q;
    if (commit && !upd_is_jal_i) begin
      ghr_d = (ghr_q << 1) | GHR_W'(upd_taken_i);
    end
  end

  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (commit) begin
      br_count_d = br_count_q + 32'd1;
      if (upd_mispred_i) mp_count_d = mp_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q      <= '0;
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      ghr_q      <= ghr_d;
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count_o = br_count_q;
  assign mp_count_o = mp_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_predictor_gshare
// Purpose : Self-checking bench for branch_predictor_gshare. One bimodal and
//           one gshare instance share the same stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_predictor_gshare;
  import branch_predictor_gshare_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] pc_if;
  logic        upd_valid, upd_is_jal, upd_taken, upd_mispred;
  logic [31:0] upd_pc, upd_target;
  logic [5:0]  upd_ghr;

  logic        bi_taken, bi_hit, gs_taken, gs_hit;
  logic [31:0] bi_target, gs_target, bi_br, bi_mp, gs_br, gs_mp;
  logic [5:0]  bi_ghr, gs_ghr;

  always #5 clk = ~clk;

  branch_predictor_gshare #(
    .BHT_IDX(6), .BTB_IDX(5), .GHR_W(6), .CNT_W(2), .MODE(BRP_BIMODAL)
  ) dut_bi (
    .clk(clk), .rst(rst), .stall_i(stall), .pc_if_i(pc_if),
    .pred_taken_o(bi_taken), .pred_hit_o(bi_hit), .pred_target_o(bi_target),
    .pred_ghr_o(bi_ghr), .upd_valid_i(upd_valid), .upd_is_jal_i(upd_is_jal),
    .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
    .br_count_o(bi_br), .mp_count_o(bi_mp)
  );

  branch_predictor_gshare #(
    .BHT_IDX(6), .BTB_IDX(5), .GHR_W(6), .CNT_W(2), .MODE(BRP_GSHARE)
  ) dut_gs (
    .clk(clk), .rst(rst), .stall_i(stall), .pc_if_i(pc_if),
    .pred_taken_o(gs_taken), .pred_hit_o(gs_hit), .pred_target_o(gs_target),
    .pred_ghr_o(gs_ghr), .upd_valid_i(upd_valid), .upd_is_jal_i(upd_is_jal),
    .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
    .br_count_o(gs_br), .mp_count_o(gs_mp)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    logic        st, v, j;
    logic [31:0] upc;
    logic        t;
    logic [31:0] utgt;
    logic        mp;
    logic [31:0] pc;
    logic        e_taken, e_hit;
    logic [31:0] e_tgt;
    logic [5:0]  e_ghr;
    logic [31:0] e_br, e_mp;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic st, v, j, input logic [31:0] upc, input logic t,
                              input logic [31:0] utgt, input logic mp, input logic [31:0] pc,
                              input logic e_taken, e_hit, input logic [31:0] e_tgt,
                              input logic [5:0] e_ghr, input logic [31:0] e_br, e_mp);
    vec_t r;
    r.st = st; r.v = v; r.j = j; r.upc = upc; r.t = t; r.utgt = utgt; r.mp = mp; r.pc = pc;
    r.e_taken = e_taken; r.e_hit = e_hit; r.e_tgt = e_tgt; r.e_ghr = e_ghr;
    r.e_br = e_br; r.e_mp = e_mp;
    return r;
  endfunction

  task automatic idle_inputs();
    stall = 0; upd_valid = 0; upd_is_jal = 0; upd_taken = 0; upd_mispred = 0;
    upd_pc = 0; upd_target = 0; upd_ghr = 0;
  endtask

  initial begin
    logic [5:0] ghr_m;
    logic       exp_pred, act_t;

    // Expectations below are for the bimodal instance; every vector is
    // checked just before the edge that commits its update.
    //              st v  j  upd_pc        t  upd_tgt       mp pc_if          tk hit target         ghr    br  mp
    vecs[0]  = mk(0, 0, 0, 32'h0,       0, 32'h0,     0, 32'h60,       0, 0, 32'h64,       6'h00, 0, 0);
    vecs[1]  = mk(0, 1, 0, 32'h100,     1, 32'h80,    1, 32'h100,      0, 0, 32'h104,      6'h00, 0, 0);
    vecs[2]  = mk(0, 1, 0, 32'h100,     1, 32'h80,    0, 32'h100,      1, 1, 32'h80,       6'h01, 1, 1);
    vecs[3]  = mk(0, 1, 0, 32'h100,     0, 32'h0,     1, 32'h100,      1, 1, 32'h80,       6'h03, 2, 1);
    vecs[4]  = mk(0, 1, 0, 32'h100,     0, 32'h0,     1, 32'h100,      1, 1, 32'h80,       6'h06, 3, 2);
    vecs[5]  = mk(0, 1, 0, 32'h100,     0, 32'h0,     0, 32'h100,      0, 1, 32'h104,      6'h0C, 4, 3);
    vecs[6]  = mk(0, 1, 0, 32'h100,     1, 32'h80,    1, 32'h100,      0, 1, 32'h104,      6'h18, 5, 3);
    vecs[7]  = mk(0, 0, 0, 32'h0,       0, 32'h0,     0, 32'h100,      0, 1, 32'h104,      6'h31, 6, 4);
    vecs[8]  = mk(0, 1, 1, 32'h200,     1, 32'h400,   1, 32'h200,      0, 0, 32'h204,      6'h31, 6, 4);
    vecs[9]  = mk(0, 0, 0, 32'h0,       0, 32'h0,     0, 32'h200,      1, 1, 32'h400,      6'h31, 7, 5);
    vecs[10] = mk(0, 0, 0, 32'h0,       0, 32'h0,     0, 32'h100,      0, 0, 32'h104,      6'h31, 7, 5);
    vecs[11] = mk(1, 1, 0, 32'h100,     1, 32'h80,    1, 32'h100,      0, 0, 32'h104,      6'h31, 7, 5);
    vecs[12] = mk(1, 1, 0, 32'h100,     1, 32'h80,    1, 32'h100,      0, 0, 32'h104,      6'h31, 7, 5);
    vecs[13] = mk(1, 1, 0, 32'h100,     1, 32'h80,    1, 32'h100,      0, 0, 32'h104,      6'h31, 7, 5);
    vecs[14] = mk(0, 1, 0, 32'h100,     1, 32'h80,    1, 32'h100,      0, 0, 32'h104,      6'h31, 7, 5);
    vecs[15] = mk(0, 0, 0, 32'h0,       0, 32'h0,     0, 32'h100,      1, 1, 32'h80,       6'h23, 8, 6);
    vecs[16] = mk(0, 0, 0, 32'h0,       0, 32'h0,     0, 32'hFFFFFFFC, 0, 0, 32'h0,        6'h23, 8, 6);

    rst = 1; pc_if = 32'h60;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // ---------------- table-driven bimodal sequence ----------------
    for (int i = 0; i < 17; i++) begin
      stall = vecs[i].st; upd_valid = vecs[i].v; upd_is_jal = vecs[i].j;
      upd_pc = vecs[i].upc; upd_taken = vecs[i].t; upd_target = vecs[i].utgt;
      upd_mispred = vecs[i].mp; pc_if = vecs[i].pc; upd_ghr = 6'h0;
      #2;
      chk($sformatf("v%0d pred_taken", i),  32'(bi_taken),  32'(vecs[i].e_taken));
      chk($sformatf("v%0d pred_hit", i),    32'(bi_hit),    32'(vecs[i].e_hit));
      chk($sformatf("v%0d pred_target", i), bi_target,     vecs[i].e_tgt);
      chk($sformatf("v%0d pred_ghr", i),    32'(bi_ghr),    32'(vecs[i].e_ghr));
      chk($sformatf("v%0d br_count", i),    bi_br,         vecs[i].e_br);
      chk($sformatf("v%0d mp_count", i),    bi_mp,         vecs[i].e_mp);
      @(posedge clk); #1;
    end

    // ---------------- asynchronous reset between edges ----------------
    idle_inputs();
    @(negedge clk);
    pc_if = 32'h100;
    #1;
    chk("pre_rst pred_taken", 32'(bi_taken), 32'd1);
    rst = 1;
    #1;
    chk("async_rst pred_taken",  32'(bi_taken), 32'd0);
    chk("async_rst pred_hit",    32'(bi_hit),   32'd0);
    chk("async_rst pred_target", bi_target,     32'h104);
    chk("async_rst pred_ghr",    32'(bi_ghr),   32'd0);
    chk("async_rst br_count",    bi_br,         32'd0);
    chk("async_rst mp_count",    bi_mp,         32'd0);
    chk("async_rst gs br_count", gs_br,         32'd0);
    @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // ---------------- counter saturation: 255 increments ----------------
    upd_valid = 1; upd_pc = 32'h100; upd_taken = 1; upd_target = 32'h80;
    repeat (255) begin
      @(posedge clk); #1;
    end
    upd_valid = 0;
    #1;
    chk("sat255 pred_taken", 32'(bi_taken), 32'd1);
    chk("sat255 br_count",   bi_br,         32'd255);
    upd_valid = 1; upd_taken = 0;
    @(posedge clk); #1;
    upd_valid = 0;
    #1;
    chk("sat255+NT pred_taken", 32'(bi_taken), 32'd1);
    chk("sat255+NT br_count",   bi_br,         32'd256);

    // ---------------- gshare: alternating T/NT at 0x300 ----------------
    @(negedge clk); rst = 1;
    #1; idle_inputs();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    ghr_m = 6'h0;
    for (int k = 0; k < 20; k++) begin
      act_t    = (k % 2 == 0);
      // Each history pattern is followed by one fixed outcome; after four
      // mispredicts on the taken side all patterns have been trained.
      exp_pred = act_t && (k >= 8);
      pc_if = 32'h300; upd_valid = 1; upd_is_jal = 0; upd_pc = 32'h300;
      upd_ghr = ghr_m; upd_taken = act_t; upd_target = 32'h500;
      upd_mispred = (exp_pred != act_t);
      #2;
      chk($sformatf("gs k%0d pred_taken", k), 32'(gs_taken), 32'(exp_pred));
      chk($sformatf("gs k%0d pred_ghr", k),   32'(gs_ghr),   32'(ghr_m));
      if (k >= 1) chk($sformatf("gs k%0d pred_hit", k), 32'(gs_hit), 32'd1);
      chk($sformatf("gs k%0d pred_target", k), gs_target, exp_pred ? 32'h500 : 32'h304);
      if (k >= 12) chk($sformatf("gs k%0d mp_stable", k), gs_mp, 32'd4);
      ghr_m = (ghr_m << 1) | 6'(act_t);
      @(posedge clk); #1;
    end
    idle_inputs();
    #1;
    chk("gs final br_count", gs_br, 32'd20);
    chk("gs final mp_count", gs_mp, 32'd4);
    chk("gs final ghr",      32'(gs_ghr), 32'(ghr_m));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
